// File: rtl/seg7_display_mux.sv
// 4-digit common-anode 7-segment display driver for the clock's HH:MM time.
// Scans M2, M1, H2, H1 in turn, blinks the field under adjustment and drives
// a blinking colon dot. All pin outputs are registered (1-cycle latency).
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   H1, H2, M1, M2  BCD time digits (hours tens/units, minutes tens/units)
//   adjust          time-adjust mode active
//   sel_hour        hours field selected for adjustment
//   sel_min         minutes field selected for adjustment
//   anode[3:0]      digit enables, active-low; bit0 = M2, bit3 = H1
//   seg[6:0]        segments {g,f,e,d,c,b,a}, active-low
//   dp              decimal point (colon), active-low

module seg7_display_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] H1,
    input  logic [3:0] H2,
    input  logic [2:0] M1,
    input  logic [3:0] M2,
    input  logic       adjust,
    input  logic       sel_hour,
    input  logic       sel_min,
    output logic [3:0] anode,
    output logic [6:0] seg,
    output logic       dp
);

    // Counter widths; the guard keeps a legal width if a DIV of 1 slips in.
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    // Terminal counts, sized to the counters so non-power-of-two DIVs fit.
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_DIV - 1);

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]    digit_idx_q,   digit_idx_d;
    logic [BW-1:0] blink_cnt_q,   blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [3:0]    anode_q,       anode_d;
    logic [6:0]    seg_q,         seg_d;
    logic          dp_q,          dp_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic       refresh_wrap;
    logic       blink_wrap;
    logic [3:0] digit_val;
    logic [3:0] digit_lim;
    logic       digit_legal;
    logic       hour_blank;
    logic       min_blank;
    logic       digit_blank;
    logic [6:0] digit_seg;
    logic       colon_on;

    assign refresh_wrap = (refresh_cnt_q == REFRESH_MAX);
    assign blink_wrap   = (blink_cnt_q == BLINK_MAX);

    // Refresh counter and digit index.
    always_comb begin
        refresh_cnt_d = refresh_cnt_q + RW'(1);
        digit_idx_d   = digit_idx_q;
        if (refresh_wrap) begin
            refresh_cnt_d = '0;
            digit_idx_d   = digit_idx_q + 2'd1;
        end
    end

    // Blink counter runs continuously, independent of adjust.
    always_comb begin
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
        if (blink_wrap) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Pick the digit for the current scan position together with the
    // largest value that digit may legally hold.
    always_comb begin
        digit_val = M2;
        digit_lim = 4'd9;
        unique case (digit_idx_q)
            2'd0: begin
                digit_val = M2;
                digit_lim = 4'd9;
            end
            2'd1: begin
                digit_val = {1'b0, M1};
                digit_lim = 4'd5;
            end
            2'd2: begin
                digit_val = H2;
                digit_lim = 4'd9;
            end
            2'd3: begin
                digit_val = {2'b00, H1};
                digit_lim = 4'd2;
            end
        endcase
    end

    assign digit_legal = (digit_val <= digit_lim);

    // BCD to active-low segments; anything outside the digit's legal
    // range is shown as a dash rather than a wrong numeral.
    always_comb begin
        digit_seg = SEG_DASH;
        if (digit_legal) begin
            case (digit_val)
                4'd0:    digit_seg = 7'b1000000;
                4'd1:    digit_seg = 7'b1111001;
                4'd2:    digit_seg = 7'b0100100;
                4'd3:    digit_seg = 7'b0110000;
                4'd4:    digit_seg = 7'b0011001;
                4'd5:    digit_seg = 7'b0010010;
                4'd6:    digit_seg = 7'b0000010;
                4'd7:    digit_seg = 7'b1111000;
                4'd8:    digit_seg = 7'b0000000;
                4'd9:    digit_seg = 7'b0010000;
                default: digit_seg = SEG_DASH;
            endcase
        end
    end

    // Blanking of the field under adjustment on the "off" blink phase.
    assign hour_blank  = adjust & sel_hour & blink_phase_q;
    assign min_blank   = adjust & sel_min & blink_phase_q;
    assign digit_blank = digit_idx_q[1] ? hour_blank : min_blank;

    // Colon sits on H2; it blinks normally and holds steady in adjust.
    assign colon_on = (digit_idx_q == 2'd2)
                    & (~blink_phase_q | adjust)
                    & ~digit_blank;

    // Next pin values.
    always_comb begin
        anode_d = 4'b1111;
        seg_d   = SEG_OFF;
        dp_d    = ~colon_on;
        if (!digit_blank) begin
            anode_d[digit_idx_q] = 1'b0;
            seg_d                = digit_seg;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt_q <= '0;
            digit_idx_q   <= 2'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            anode_q       <= 4'b1111;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            digit_idx_q   <= digit_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            anode_q       <= anode_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign anode = anode_q;
    assign seg   = seg_q;
    assign dp    = dp_q;

endmodule

// File: tb/tb_seg7_display_mux.sv
// Self-checking bench for seg7_display_mux with small dividers.
// Reference model derives scan index and blink phase from elapsed cycles.

module tb_seg7_display_mux;

    localparam int RDIV = 4;
    localparam int BDIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] H1 = '0;
    logic [3:0] H2 = '0;
    logic [2:0] M1 = '0;
    logic [3:0] M2 = '0;
    logic       adjust = 1'b0;
    logic       sel_hour = 1'b0;
    logic       sel_min = 1'b0;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;
    // Clock edges taken out of reset since the last reset edge.
    int n = 0;

    logic [6:0] segtab [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    seg7_display_mux #(
        .REFRESH_DIV(RDIV),
        .BLINK_DIV  (BDIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .H1      (H1),
        .H2      (H2),
        .M1      (M1),
        .M2      (M2),
        .adjust  (adjust),
        .sel_hour(sel_hour),
        .sel_min (sel_min),
        .anode   (anode),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    // One clock edge with rst=r; inputs must already be driven.
    task automatic step(input logic r);
        int         idx;
        int         ph;
        int         val;
        int         lim;
        logic       blank;
        logic [3:0] ea;
        logic [6:0] es;
        logic       edp;
        idx = (n / RDIV) % 4;
        ph  = (n / BDIV) % 2;
        case (idx)
            0:       begin val = int'(M2); lim = 9; end
            1:       begin val = int'(M1); lim = 5; end
            2:       begin val = int'(H2); lim = 9; end
            default: begin val = int'(H1); lim = 2; end
        endcase
        blank = adjust && (ph == 1) &&
                ((idx >= 2) ? sel_hour : sel_min);
        ea = 4'hf;
        if (!blank) ea[idx] = 1'b0;
        es  = (val > lim) ? 7'b0111111 : segtab[val];
        edp = !((idx == 2) && (ph == 0 || adjust) && !blank);
        rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            chk("rst_anode", 32'(anode), 32'hf);
            chk("rst_seg", 32'(seg), 32'h7f);
            chk("rst_dp", 32'(dp), 32'h1);
            n = 0;
        end else begin
            chk("anode", 32'(anode), 32'(ea));
            if (!blank) chk("seg", 32'(seg), 32'(es));
            chk("dp", 32'(dp), 32'(edp));
            n++;
        end
    endtask

    initial begin
        // Time 12:34, no adjust.
        H1 = 2'd1; H2 = 4'd2; M1 = 3'd3; M2 = 4'd4;
        repeat (3) step(1'b1);
        repeat (40) step(1'b0);

        // Hours under adjustment.
        adjust = 1'b1; sel_hour = 1'b1;
        repeat (40) step(1'b0);

        // Both fields under adjustment, then leave adjust.
        sel_min = 1'b1;
        repeat (36) step(1'b0);
        adjust = 1'b0;
        repeat (8) step(1'b0);
        sel_hour = 1'b0; sel_min = 1'b0;

        // Out-of-range digits show a dash; H2=9 stays legal.
        M2 = 4'd12; M1 = 3'd7; H1 = 2'd3; H2 = 4'd9;
        repeat (20) step(1'b0);

        // Reset asserted while digit 2 is lit.
        H1 = 2'd2; H2 = 4'd3; M1 = 3'd5; M2 = 4'd9;
        for (int k = 0; k < 16 && ((n / RDIV) % 4) != 2; k++)
            step(1'b0);
        chk("midscan_idx", 32'((n / RDIV) % 4), 32'd2);
        step(1'b1);
        repeat (24) step(1'b0);

        // Randomised inputs, occasional resets.
        repeat (800) begin
            H1       = 2'($urandom_range(0, 3));
            H2       = 4'($urandom_range(0, 15));
            M1       = 3'($urandom_range(0, 7));
            M2       = 4'($urandom_range(0, 15));
            adjust   = ($urandom_range(0, 3) != 0);
            sel_hour = 1'($urandom);
            sel_min  = 1'($urandom);
            step($urandom_range(0, 99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_display_mux.md
Name: seg7_display_mux

Overview:
- Downstream display stage for the clock's time counter.
- Consumes the four BCD time digits (H1 H2 : M1 M2) and drives a 4-digit common-anode 7-segment display.
- Time-multiplexes the digits, blinks the field being adjusted, and drives a blinking colon dot.
- Sits between the timekeeping block and the board pins. All outputs are registered.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit before advancing (>=2).
- BLINK_DIV, 25000000, clk cycles per blink half-period (>=2).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- H1  input  2  hours tens digit (legal 0-2)
- H2  input  4  hours units digit (legal 0-9)
- M1  input  3  minutes tens digit (legal 0-5)
- M2  input  4  minutes units digit (legal 0-9)
- adjust  input  1  time-adjust mode active
- sel_hour  input  1  hours field selected for adjustment
- sel_min  input  1  minutes field selected for adjustment
- anode  output  4  digit enables, active-low; bit0 = rightmost (M2), bit3 = H1
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low

Behaviour:
- Single clock domain; reset is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset values: anode=4'b1111, seg=7'b1111111, dp=1. Internal refresh counter=0, digit index=0, blink counter=0, blink_phase=0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the wrap, the digit index advances 0->1->2->3->0.
  - Digit mapping: index 0=M2, 1=M1, 2=H2, 3=H1.
- Blink counter:
  - Counts 0..BLINK_DIV-1 continuously, regardless of adjust.
  - On its wrap, blink_phase toggles.
  - The refresh and blink counters are independent; simultaneous wraps are both honoured in the same cycle.
- Output register (1-cycle latency): each cycle, anode/seg/dp load the decode of the current index and current inputs.
  - Input changes appear on the pins on the next edge.
  - Mid-frame input changes take effect immediately for the lit digit; there is no frame-level latching.
- Anode: the bit for the current index is 0, all other bits 1, except when that digit is blanked, in which case all four bits are 1.
- Blanking:
  - Digits 2,3 are blanked when adjust & sel_hour & blink_phase.
  - Digits 0,1 are blanked when adjust & sel_min & blink_phase.
  - Both selects asserted blanks both fields.
  - With adjust=0, nothing is blanked regardless of the selects.
- Segment decode (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Out-of-range values (H1=3, M1=6/7, H2 or M2 = 10-15) display a dash, 0111111. This is not an error; it is display only.
- No leading-zero suppression: H1=0 displays "0".
- Colon dot: dp=0 only when index==2, and only if blink_phase==0 or adjust==1 (steady in adjust mode). Otherwise dp=1.
- A blanked digit also forces dp=1.
- Reset asserted mid-scan: all outputs return to reset values on the next edge, and scanning restarts at index 0.
- Width rules:
  - Refresh counter width is clog2(REFRESH_DIV); blink counter width is clog2(BLINK_DIV).
  - Comparisons are against DIV-1 and must not overflow for non-power-of-two DIVs.

Test Plan (REFRESH_DIV=4, BLINK_DIV=16):
1. Reset, H=1 2, M=3 4, adjust=0.
   - During reset: anode=1111, seg=1111111, dp=1.
   - After release: anode=1110 with seg=0011001 (4) for 4 cycles.
   - Then 1101 with 0110000 (3), then 1011 with 0100100 (2) and dp=0, then 0111 with 1111001 (1); then wraps to index 0.
2. Blink colon: same time. At index 2, dp=0 while blink_phase=0. After 16 cycles (phase=1), dp=1 at index 2. dp stays 1 at all other indices.
3. Adjust hours: adjust=1, sel_hour=1.
   - While phase=1: anode=1111 during index 2,3; digits 0,1 still light normally.
   - dp=1 at index 2 during blanking.
   - While phase=0, all digits are lit and dp is steady 0 at index 2.
4. Adjust both fields: sel_hour=sel_min=1, phase=1 -> anode=1111 for all indices. Drop adjust to 0 -> normal scan resumes on the next edge.
5. Illegal digits: M2=4'd12, M1=3'd7, H1=2'd3 -> seg=0111111 at indices 0, 1, 3. Valid H2=9 -> 0010000.
6. Mid-scan reset: assert rst at index 2 for one cycle.
   - Next edge: anode=1111, seg=1111111, dp=1.
   - After release, the scan restarts at index 0 with a full 4-cycle dwell, and blink_phase=0.
